// File: rtl/byte_stream_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// byte_stream_arb_pkg : shared state encoding and constants for byte_stream_arb
// Revision: 1.0
// ---------------------------------------------------------------------------
package byte_stream_arb_pkg;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_grant0 = 2'd1;
  localparam logic [1:0] c_st_grant1 = 2'd2;
  localparam logic [1:0] c_st_pad    = 2'd3;

  localparam logic [7:0] PAD_BYTE = 8'h00;

  localparam int BURST_PAIRS_DEFAULT = 4;
  localparam int STALL_LIMIT_DEFAULT = 15;

endpackage
`default_nettype wire

// File: rtl/byte_stream_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// byte_stream_arb : two-source byte arbiter feeding an 8-to-16 packer
// Revision: 1.0
// ---------------------------------------------------------------------------
module byte_stream_arb
  import byte_stream_arb_pkg::*;
#(
  parameter int BURST_PAIRS = BURST_PAIRS_DEFAULT,
  parameter int STALL_LIMIT = STALL_LIMIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s0_data,
  input  logic       s0_vld,
  output logic       s0_rdy,
  input  logic [7:0] s1_data,
  input  logic       s1_vld,
  output logic       s1_rdy,
  output logic [7:0] m_data,
  output logic       m_vld,
  output logic       m_ch,
  output logic       m_sof,
  output logic       busy,
  output logic       stall_err
);

  localparam int c_byte_w = $clog2(2 * BURST_PAIRS);
  localparam int c_stall_w = $clog2(STALL_LIMIT + 1);
  localparam logic [c_byte_w-1:0]  c_byte_last  = c_byte_w'(2 * BURST_PAIRS - 1);
  localparam logic [c_stall_w-1:0] c_stall_last = c_stall_w'(STALL_LIMIT - 1);

  logic [1:0]           r_state;
  logic [c_byte_w-1:0]  r_byte_cnt;
  logic [c_stall_w-1:0] r_stall_cnt;
  logic                 r_last;
  logic [7:0]           r_m_data;
  logic                 r_m_vld;
  logic                 r_m_ch;
  logic                 r_m_sof;
  logic                 r_stall_err;

  logic       w_sel_vld;
  logic [7:0] w_sel_data;
  logic       w_pick;
  logic       w_burst_end;
  logic       w_stall_hit;

  always_comb begin
    w_sel_vld   = (r_state == c_st_grant1) ? s1_vld : s0_vld;
    w_sel_data  = (r_state == c_st_grant1) ? s1_data : s0_data;
    // On contention the source that was not served last wins.
    w_pick      = (s0_vld && s1_vld) ? ~r_last : s1_vld;
    w_burst_end = (r_byte_cnt == c_byte_last);
    w_stall_hit = (r_stall_cnt == c_stall_last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_st_idle;
      r_byte_cnt  <= '0;
      r_stall_cnt <= '0;
      r_last      <= 1'b1;
      r_m_data    <= 8'h00;
      r_m_vld     <= 1'b0;
      r_m_ch      <= 1'b0;
      r_m_sof     <= 1'b0;
      r_stall_err <= 1'b0;
    end else begin
      r_m_vld     <= 1'b0;
      r_m_sof     <= 1'b0;
      r_stall_err <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (s0_vld || s1_vld) begin
            r_state     <= w_pick ? c_st_grant1 : c_st_grant0;
            r_last      <= w_pick;
            r_byte_cnt  <= '0;
            r_stall_cnt <= '0;
          end
        end
        c_st_grant0, c_st_grant1: begin
          if (w_sel_vld) begin
            r_m_data    <= w_sel_data;
            r_m_vld     <= 1'b1;
            r_m_ch      <= r_last;
            r_m_sof     <= (r_byte_cnt == '0);
            r_stall_cnt <= '0;
            if (w_burst_end) begin
              r_state    <= c_st_idle;
              r_byte_cnt <= '0;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end else if (w_stall_hit) begin
            // An odd byte count needs a filler byte to keep 16-bit pairing aligned.
            r_state     <= r_byte_cnt[0] ? c_st_pad : c_st_idle;
            r_byte_cnt  <= '0;
            r_stall_cnt <= '0;
          end else begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
          end
        end
        c_st_pad: begin
          r_m_data    <= PAD_BYTE;
          r_m_vld     <= 1'b1;
          r_m_ch      <= r_last;
          r_stall_err <= 1'b1;
          r_state     <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign s0_rdy    = (r_state == c_st_grant0);
  assign s1_rdy    = (r_state == c_st_grant1);
  assign busy      = (r_state == c_st_grant0) || (r_state == c_st_grant1);
  assign m_data    = r_m_data;
  assign m_vld     = r_m_vld;
  assign m_ch      = r_m_ch;
  assign m_sof     = r_m_sof;
  assign stall_err = r_stall_err;

endmodule
`default_nettype wire

// File: doc/byte_stream_arb.md
BYTE_STREAM_ARB -- requirements
Module: byte_stream_arb

Interface
REQ-001 Parameter BURST_PAIRS, default 4: byte pairs (16-bit words) carried per grant, range 1..64.
REQ-002 Parameter STALL_LIMIT, default 15: consecutive stalled cycles inside a grant before forced release, range 2..255.
REQ-003 Port clk, input, 1: single clock; every register is rising-edge triggered.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Ports s0_data / s1_data, input, 8: byte from source 0 / source 1.
REQ-006 Ports s0_vld / s1_vld, input, 1: source byte valid; also acts as the request.
REQ-007 Ports s0_rdy / s1_rdy, output, 1: source byte accepted when vld and rdy are both high on a clock edge.
REQ-008 Port m_data, output, 8: byte to the downstream 8-to-16 packer.
REQ-009 Port m_vld, output, 1: m_data valid; downstream always accepts.
REQ-010 Port m_ch, output, 1: source index of the current m_data.
REQ-011 Port m_sof, output, 1: high with the first byte of each grant.
REQ-012 Port busy, output, 1: high in any GRANT state.
REQ-013 Port stall_err, output, 1: one-cycle pulse when a grant is released on an odd byte.

Function
REQ-014 The FSM SHALL have states IDLE, GRANT0, GRANT1 and PAD.
REQ-015 In IDLE:
- s0_vld only -> GRANT0; s1_vld only -> GRANT1.
- Both high -> grant the source not served last; after reset source 0 wins.
- Neither high -> stay in IDLE.
REQ-016 sN_rdy SHALL be high exactly while the state is GRANTN; this is a decode of registered state only.
REQ-017 Each accepted byte SHALL appear on m_data/m_vld/m_ch one cycle after acceptance (latency 1). m_vld SHALL be low on every other cycle.
REQ-018 A byte counter (0..2*BURST_PAIRS-1) SHALL increment per accepted byte and clear on entry to GRANTx.
REQ-019 Acceptance of byte 2*BURST_PAIRS-1 SHALL move the FSM to IDLE on the same edge, so every burst boundary has exactly one IDLE arbitration cycle.
REQ-020 A stall counter SHALL:
- count consecutive cycles in GRANTx with sN_vld low;
- clear on any acceptance;
- clear on leaving GRANTx.
REQ-021 Stall counter reaching STALL_LIMIT with an even byte count SHALL return the FSM to IDLE with no output byte.
REQ-022 Stall counter reaching STALL_LIMIT with an odd byte count SHALL go to PAD.
REQ-023 PAD SHALL, for one cycle:
- emit m_data=8'h00, m_vld=1, m_ch equal to the granted source;
- pulse stall_err;
then return to IDLE, so the downstream 16-bit pairing stays aligned.
REQ-024 A byte arriving on the same edge the stall limit is reached SHALL be accepted, and the stall release is cancelled.
REQ-025 The last-served pointer SHALL update on entry to GRANTx and SHALL NOT change in PAD.
REQ-026 m_sof SHALL be high only with the output copy of byte 0 of a grant.

Reset
REQ-027 Asserting rst at any time SHALL immediately set:
- state IDLE;
- both counters 0;
- last-served pointer to source 1, so source 0 wins first;
- all outputs 0, including m_data=8'h00.
REQ-028 A partial burst in flight during reset SHALL be discarded, with no pad byte emitted.
REQ-029 After rst deasserts, the first grant decision SHALL occur on the first clock edge.

Structure
REQ-030 A shared package SHALL hold:
- the FSM state encoding (2 bits);
- the PAD_BYTE constant 8'h00;
- default values for BURST_PAIRS and STALL_LIMIT.
REQ-031 The design SHALL be a single module with no sub-modules.
REQ-032 Counter widths SHALL be derived from the parameters using clog2.

Verification
REQ-033 Single source: s0_vld held high with BURST_PAIRS=4 -> 8 bytes out with m_ch=0 and m_sof on the first; s0_rdy low for one cycle; pattern repeats.
REQ-034 Contention: both sources held high from reset -> bursts alternate ch0,ch1,ch0, each 8 bytes, one idle cycle between bursts.
REQ-035 Even stall: s1 sends 4 bytes then drops vld -> grant released after 15 stalled cycles; no pad byte; stall_err stays 0.
REQ-036 Odd stall: s0 sends 3 bytes (A1,A2,A3) then stalls -> output sequence A1,A2,A3,00; stall_err pulses once aligned with the 00.
REQ-037 Edge case: byte arrives on stall cycle 15 -> byte accepted, no release; burst continues to 8 bytes.
REQ-038 Reset mid-burst: rst asserted after 5 bytes -> all outputs 0 immediately; after release, source 0 is granted first with the byte counter at 0.
